// File: rtl/riscv_decode_stage_if.sv
// Handshake and decoded-field bundle for the RISC-V decode stage.
// The slave modport is the decode stage's view. The master modport is the
// view of the surrounding fetch/register-read logic.
interface riscv_decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) ();
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      instr_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [2:0]       type_o;
  logic [6:0]       opcode_o;
  logic [4:0]       rd_o;
  logic [2:0]       funct3_o;
  logic [4:0]       rs1_o;
  logic [4:0]       rs2_o;
  logic [6:0]       funct7_o;
  logic [XLEN-1:0]  imm_o;
  logic             illegal_o;
  logic [CNT_W-1:0] dec_cnt_o;

  modport slave (
    input  flush_i, in_valid_i, instr_i, out_ready_i,
    output in_ready_o, out_valid_o, type_o, opcode_o, rd_o, funct3_o,
           rs1_o, rs2_o, funct7_o, imm_o, illegal_o, dec_cnt_o
  );

  modport master (
    output flush_i, in_valid_i, instr_i, out_ready_i,
    input  in_ready_o, out_valid_o, type_o, opcode_o, rd_o, funct3_o,
           rs1_o, rs2_o, funct7_o, imm_o, illegal_o, dec_cnt_o
  );
endinterface

// File: rtl/riscv_decode_stage.sv
// Registered RV32/RV64 base-ISA decode stage. Each word is decoded on entry.
// The result is held in a main output register. An optional skid register
// sits behind it for full throughput. A saturating counter tracks every
// output handshake.
module riscv_decode_stage #(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  riscv_decode_stage_if.slave bus
);

  typedef enum logic [2:0] {
    TYPE_R   = 3'b000,
    TYPE_I   = 3'b001,
    TYPE_S   = 3'b010,
    TYPE_B   = 3'b011,
    TYPE_U   = 3'b100,
    TYPE_J   = 3'b101,
    TYPE_UNK = 3'b111
  } instr_type_e;

  typedef struct packed {
    instr_type_e     itype;
    logic            illegal;
    logic [XLEN-1:0] imm;
    logic [31:0]     instr;
  } entry_t;

  localparam entry_t ENTRY_RST = '{itype: TYPE_UNK, illegal: 1'b0, imm: '0, instr: '0};

  // Classify one raw word and build its sign-extended immediate.
  function automatic entry_t decode(input logic [31:0] w);
    entry_t      e;
    logic [31:0] imm32;
    e.instr   = w;
    e.itype   = TYPE_UNK;
    e.illegal = 1'b1;
    if (w[1:0] == 2'b11) begin
      e.illegal = 1'b0;
      case (w[6:0])
        7'b0110011:                                     e.itype = TYPE_R;
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: e.itype = TYPE_I;
        7'b0100011:                                     e.itype = TYPE_S;
        7'b1100011:                                     e.itype = TYPE_B;
        7'b0110111, 7'b0010111:                         e.itype = TYPE_U;
        7'b1101111:                                     e.itype = TYPE_J;
        default:                                        e.illegal = 1'b1;
      endcase
    end
    case (e.itype)
      TYPE_I:  imm32 = {{20{w[31]}}, w[31:20]};
      TYPE_S:  imm32 = {{20{w[31]}}, w[31:25], w[11:7]};
      TYPE_B:  imm32 = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      TYPE_U:  imm32 = {w[31:12], 12'b0};
      TYPE_J:  imm32 = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    // Signed operand, so widening to XLEN replicates bit 31.
    e.imm = XLEN'($signed(imm32));
    return e;
  endfunction

  logic             main_valid_q, main_valid_d;
  entry_t           main_q, main_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready;
  logic             accept;
  logic             consume;
  entry_t           in_entry;

  assign in_entry = decode(bus.instr_i);
  assign consume  = main_valid_q & bus.out_ready_i;
  // A flush drops any word offered in the same cycle.
  assign accept   = bus.in_valid_i & in_ready & ~bus.flush_i;

  if (SKID_EN) begin : g_skid
    logic   skid_valid_q, skid_valid_d;
    entry_t skid_q, skid_d;

    // The skid register only fills while main is stalled, so ready is simply "skid empty".
    assign in_ready = ~skid_valid_q;

    // Main/skid next state: the skid drains into main before any new word lands there.
    always_comb begin
      // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
      main_valid_d = main_valid_q;
      main_d       = main_q;
      skid_valid_d = skid_valid_q;
      skid_d       = skid_q;
      if (bus.flush_i) begin
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end else if (!main_valid_q || consume) begin
        if (skid_valid_q) begin
          main_d       = skid_q;
          main_valid_d = 1'b1;
          skid_valid_d = 1'b0;
        end else begin
          main_valid_d = accept;
          if (accept) main_d = in_entry;
        end
      end else if (accept) begin
        skid_d       = in_entry;
        skid_valid_d = 1'b1;
      end
    end

    // Skid register state.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        skid_valid_q <= 1'b0;
        skid_q       <= ENTRY_RST;
      end else begin
        skid_valid_q <= skid_valid_d;
        skid_q       <= skid_d;
      end
    end
  end else begin : g_noskid
    // A consume and an accept in the same cycle replace the entry without a bubble.
    assign in_ready = bus.out_ready_i | ~main_valid_q;

    // Single output register: load on accept, otherwise empty on consume.
    always_comb begin
      main_valid_d = main_valid_q;
      main_d       = main_q;
      if (bus.flush_i) begin
        main_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else if (consume) begin
        main_valid_d = 1'b0;
      end
    end
  end

  // Saturating count of output handshakes. Illegal entries count too.
  always_comb begin
    cnt_d = cnt_q;
    if (consume && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Main output register and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      // NOTE: the held entries drive the outputs directly, and those outputs have defined reset values, so the data registers are reset along with their valid bits.
      main_q       <= ENTRY_RST;
      cnt_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every flop samples the pre-edge values.
      main_valid_q <= main_valid_d;
      main_q       <= main_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = main_valid_q;
  assign bus.type_o      = main_q.itype;
  assign bus.illegal_o   = main_q.illegal;
  assign bus.imm_o       = main_q.imm;
  assign bus.opcode_o    = main_q.instr[6:0];
  assign bus.rd_o        = main_q.instr[11:7];
  assign bus.funct3_o    = main_q.instr[14:12];
  assign bus.rs1_o       = main_q.instr[19:15];
  assign bus.rs2_o       = main_q.instr[24:20];
  assign bus.funct7_o    = main_q.instr[31:25];
  assign bus.dec_cnt_o   = cnt_q;

endmodule
